bcd_excess3_conv: RTL and testbench

BCD_EXCESS3_CONV -- requirements
Module: bcd_excess3_conv

---
 rtl/bcd_excess3_conv.sv | 150 +++++++++++++++
 tb/tb_bcd_excess3_conv.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_excess3_conv.sv
// BCD <-> Excess-3 word converter: accepts one packed word, converts one digit
// per cycle (digit 0 first), then holds the result until the sink takes it.
module bcd_excess3_conv #(
  parameter int unsigned NDIGITS = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NDIGITS-1:0]   in_data,
  input  logic                   mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NDIGITS-1:0]   out_data,
  output logic [NDIGITS-1:0]     err_mask,
  output logic                   err
);

  localparam int unsigned DATA_W = 4 * NDIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [DATA_W-1:0]   r_work;
  logic [DATA_W-1:0]   w_work_nxt;
  logic                r_mode;
  logic                w_mode_nxt;
  logic [DATA_W-1:0]   r_out_data;
  logic [DATA_W-1:0]   w_out_data_nxt;
  logic [NDIGITS-1:0]  r_err_mask;
  logic [NDIGITS-1:0]  w_err_mask_nxt;
  logic                r_err;
  logic                r_in_ready;
  logic                r_out_valid;

  logic [3:0]          w_dig_in;
  logic [3:0]          w_dig_res;
  logic                w_dig_err;

  // Select the digit addressed by the counter from the work register
  always_comb begin
    w_dig_in = 4'h0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (CNT_W'(i) == r_cnt) begin
        w_dig_in = r_work[4*i +: 4];
      end
    end
  end

  // Single-digit conversion; out-of-range digits map to 4'hF and flag an error
  always_comb begin
    w_dig_res = 4'hF;
    w_dig_err = 1'b0;
    if (!r_mode) begin
      if (w_dig_in <= 4'd9) begin
        w_dig_res = w_dig_in + 4'd3;
      end else begin
        w_dig_err = 1'b1;
      end
    end else begin
      if ((w_dig_in >= 4'd3) && (w_dig_in <= 4'd12)) begin
        w_dig_res = w_dig_in - 4'd3;
      end else begin
        w_dig_err = 1'b1;
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_work_nxt     = r_work;
    w_mode_nxt     = r_mode;
    w_out_data_nxt = r_out_data;
    w_err_mask_nxt = r_err_mask;

    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_work_nxt     = in_data;
          w_mode_nxt     = mode;
          w_cnt_nxt      = '0;
          w_err_mask_nxt = '0;
          w_state_nxt    = CONV;
        end
      end
      CONV: begin
        for (int i = 0; i < NDIGITS; i++) begin
          if (CNT_W'(i) == r_cnt) begin
            w_out_data_nxt[4*i +: 4] = w_dig_res;
            w_err_mask_nxt[i]        = w_dig_err;
          end
        end
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(NDIGITS - 1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Handshake flags are registered from the next state so they track r_state exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_work      <= '0;
      r_mode      <= 1'b0;
      r_out_data  <= '0;
      r_err_mask  <= '0;
      r_err       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_work      <= w_work_nxt;
      r_mode      <= w_mode_nxt;
      r_out_data  <= w_out_data_nxt;
      r_err_mask  <= w_err_mask_nxt;
      r_err       <= |w_err_mask_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign err_mask  = r_err_mask;
  assign err       = r_err;

endmodule

// File: tb/tb_bcd_excess3_conv.sv
// Scoreboard bench for bcd_excess3_conv (NDIGITS=4): directed words with
// hand-computed results, checked by an independent output monitor.
module tb_bcd_excess3_conv;

  localparam int unsigned ND = 4;
  localparam int unsigned DW = 4 * ND;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          mode;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [ND-1:0] err_mask;
  logic          err;

  bcd_excess3_conv #(.NDIGITS(ND), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_mask  (err_mask),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic [ND-1:0] m;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned acc_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned last_acc = 0;
  logic        prev_ov  = 1'b0;
  exp_t        mon_e;
  int unsigned mon_a;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Output monitor: latency on each rising out_valid, contents on each handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) fail_now("latency_unexpected_valid");
        else begin
          mon_a = acc_q.pop_front();
          check("latency", cyc - mon_a, 32'd4);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_output");
        else begin
          mon_e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(mon_e.d));
          check("err_mask", 32'(err_mask), 32'(mon_e.m));
          check("err",      32'(err),      32'(|mon_e.m));
        end
      end
    end
    prev_ov = out_valid;
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge
  task automatic send(input logic [DW-1:0] d, input logic m,
                      input logic [DW-1:0] ed, input logic [ND-1:0] em, input logic hold);
    int   budget;
    exp_t e;
    budget   = 50;
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    while (!in_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (!in_ready) begin
      fail_now("accept_timeout");
    end else begin
      e.d = ed;
      e.m = em;
      exp_q.push_back(e);
      @(posedge clk); #1;
      acc_q.push_back(cyc);
      last_acc = cyc;
    end
    in_data = 16'hDEAD;
    mode    = ~m;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 100;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
  endtask

  initial begin
    int budget;
    int unsigned a1;
    int unsigned a2;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    mode      = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_err_mask",  32'(err_mask),  32'd0);
    check("rst_err",       32'(err),       32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    send(16'h1234, 1'b0, 16'h4567, 4'b0000, 1'b0); drain();
    send(16'h4567, 1'b1, 16'h1234, 4'b0000, 1'b0); drain();
    send(16'hC333, 1'b1, 16'h9000, 4'b0000, 1'b0); drain();
    send(16'h9A0F, 1'b0, 16'hCF3F, 4'b0101, 1'b0); drain();
    send(16'h9090, 1'b0, 16'hC3C3, 4'b0000, 1'b0); drain();
    send(16'h3C3C, 1'b1, 16'h0909, 4'b0000, 1'b0); drain();
    send(16'h0D21, 1'b1, 16'hFFFF, 4'b1111, 1'b0); drain();

    // Sink stall in DONE
    out_ready = 1'b0;
    send(16'h5678, 1'b0, 16'h89AB, 4'b0000, 1'b0);
    budget = 20;
    while (!out_valid && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (!out_valid) fail_now("stall_valid_timeout");
    for (int k = 0; k < 10; k++) begin
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready",  32'(in_ready),  32'd0);
      check("stall_out_data",  32'(out_data),  32'h89AB);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready",  32'(in_ready),  32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("retain_out_data",   32'(out_data),  32'h89AB);
    check("retain_err_mask",   32'(err_mask),  32'd0);

    // Reset two cycles into CONV aborts the word
    send(16'h1111, 1'b0, 16'h4444, 4'b0000, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_data",  32'(out_data),  32'd0);
    check("abort_in_ready",  32'(in_ready),  32'd1);
    check("abort_err",       32'(err),       32'd0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("no_aborted_valid", 32'(out_valid), 32'd0);
    end
    send(16'h0246, 1'b0, 16'h3579, 4'b0000, 1'b0); drain();

    // Back-to-back with in_valid held
    send(16'h1357, 1'b0, 16'h468A, 4'b0000, 1'b1);
    a1 = last_acc;
    send(16'h8642, 1'b0, 16'hB975, 4'b0000, 1'b1);
    a2 = last_acc;
    in_valid = 1'b0;
    check("b2b_spacing", a2 - a1, 32'd6);
    drain();
    repeat (3) begin @(posedge clk); #1; end
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
